// File: rtl/spi_main.sv
// SPI mode-0 controller (initiator), MSB first. Optional back-to-back framing
// keeps SSN low across words when hold_cs is set at end of word.
module spi_main #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic                 clk_system,
  input  logic                 rstn_system,
  input  logic [WORD_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 hold_cs,
  output logic [WORD_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 spi_sclk,
  output logic                 spi_ssn,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned EDGES   = 2 * WORD_SIZE;
  localparam int unsigned EW      = $clog2(EDGES + 2);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
  localparam logic [EW-1:0] LAST_FALL = EW'(EDGES - 1);
  localparam logic [EW-1:0] ALL_EDGES = EW'(EDGES);
  localparam logic [EW-1:0] END_WORD  = EW'(EDGES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [EW-1:0]        edge_cnt;
  logic [WORD_SIZE-1:0] tx_sh;
  logic [WORD_SIZE-1:0] rx_sh;
  logic                 load;

  // A word can be taken from IDLE, or from the first HOLD cycle when hold_cs
  // raised tx_ready at end of word; both paths restart at SETUP.
  always_comb begin
    load = 1'b0;
    if ((state == IDLE) || (state == HOLD))
      load = tx_valid && tx_ready;
  end

  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) begin
      state    <= IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_ssn  <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (load) begin
        tx_sh    <= tx_data;
        spi_mosi <= tx_data[WORD_SIZE-1];
        spi_ssn  <= 1'b0;
        tx_ready <= 1'b0;
        busy     <= 1'b1;
        cnt      <= '0;
        edge_cnt <= '0;
        state    <= SETUP;
      end else begin
        case (state)
          IDLE: tx_ready <= 1'b1;
          SETUP, SHIFT: begin
            if (edge_cnt == END_WORD) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
              tx_ready <= hold_cs;
              cnt      <= '0;
              state    <= HOLD;
            end else if (cnt != DIV_LAST) begin
              cnt <= cnt + 1'b1;
            end else begin
              // Half-period boundary: after the last edge one more idle-low
              // half period elapses before the end-of-word cycle.
              cnt      <= '0;
              state    <= SHIFT;
              edge_cnt <= edge_cnt + 1'b1;
              if (edge_cnt != ALL_EDGES) begin
                spi_sclk <= ~spi_sclk;
                if (!spi_sclk) begin
                  rx_sh <= {rx_sh[WORD_SIZE-2:0], spi_miso};
                end else if (edge_cnt != LAST_FALL) begin
                  spi_mosi <= tx_sh[WORD_SIZE-2];
                  tx_sh    <= tx_sh << 1;
                end
              end
            end
          end
          HOLD: begin
            tx_ready <= 1'b0;
            if (cnt != DIV_LAST) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt     <= '0;
              spi_ssn <= 1'b1;
              state   <= GAP;
            end
          end
          GAP: begin
            if (cnt != GAP_LAST) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt      <= '0;
              edge_cnt <= '0;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_main.sv
// Self-checking bench for spi_main: monitor logs SPI activity per cycle and each
// test compares the log against timings and data derived from the protocol rules.
module tb_spi_main;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned G  = 4;
  localparam int unsigned D1 = 1;

  // Expected timings relative to the accept cycle (cycle 0).
  localparam int RX_LAT  = D * (2 * W + 1) + 2;
  localparam int SSN_LEN = D * (2 * W + 2) + 1;

  logic         clk_system = 1'b0;
  logic         rstn_system;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         hold_cs;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         spi_sclk;
  logic         spi_ssn;
  logic         spi_mosi;
  logic         spi_miso;

  logic [W-1:0] tx_data1;
  logic         tx_valid1;
  logic         tx_ready1;
  logic [W-1:0] rx_data1;
  logic         rx_valid1;
  logic         busy1;
  logic         sclk1;
  logic         ssn1;
  logic         mosi1;

  always #5 clk_system = ~clk_system;

  spi_main #(.WORD_SIZE(W), .CLK_DIV(D), .CS_GAP(G)) dut (
    .clk_system(clk_system), .rstn_system(rstn_system),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .hold_cs(hold_cs),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .spi_sclk(spi_sclk), .spi_ssn(spi_ssn), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_main #(.WORD_SIZE(W), .CLK_DIV(D1), .CS_GAP(G)) dut1 (
    .clk_system(clk_system), .rstn_system(rstn_system),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .hold_cs(1'b0),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
    .spi_sclk(sclk1), .spi_ssn(ssn1), .spi_mosi(mosi1), .spi_miso(mosi1)
  );

  int tests = 0;
  int fails = 0;

  // miso source: 0 constant 0, 1 constant 1, 2 loopback, 3 pattern word MSB first
  int           miso_mode = 2;
  logic [W-1:0] pat = '0;
  int unsigned  word_rises = 0;
  logic         pat_bit;
  assign pat_bit  = pat[(W - 1) - (word_rises % W)];
  assign spi_miso = (miso_mode == 2) ? spi_mosi :
                    (miso_mode == 3) ? pat_bit  : (miso_mode == 1);

  int           cyc = 0;
  logic         prev_sclk = 1'b0;
  logic         prev_ssn = 1'b1;
  int           fall_cyc = 0;
  int           rise_cyc = 0;
  bit           have_rise = 0;
  int           win_rises = 0;
  int           sclk_bad = 0;
  int           ready_busy = 0;
  logic         mosi_q[$];
  logic [W-1:0] rx_q[$];
  int           rxv_cyc_q[$];
  int           acc_cyc_q[$];
  int           low_len_q[$];
  int           win_rise_q[$];
  int           gap_q[$];

  always @(negedge clk_system) begin
    cyc++;
    if (tx_valid && tx_ready) acc_cyc_q.push_back(cyc);
    if (spi_sclk && !prev_sclk) begin
      mosi_q.push_back(spi_mosi);
      win_rises++;
      word_rises++;
    end
    if (spi_sclk && spi_ssn) sclk_bad++;
    if (tx_ready && busy) ready_busy++;
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rxv_cyc_q.push_back(cyc);
    end
    if (!spi_ssn && prev_ssn) begin
      fall_cyc = cyc;
      win_rises = 0;
      word_rises = 0;
      if (have_rise) gap_q.push_back(cyc - rise_cyc);
    end
    if (spi_ssn && !prev_ssn) begin
      rise_cyc = cyc;
      have_rise = 1;
      low_len_q.push_back(cyc - fall_cyc);
      win_rise_q.push_back(win_rises);
    end
    prev_sclk = spi_sclk;
    prev_ssn  = spi_ssn;
  end

  task automatic clear_log;
    mosi_q.delete(); rx_q.delete(); rxv_cyc_q.delete(); acc_cyc_q.delete();
    low_len_q.delete(); win_rise_q.delete(); gap_q.delete();
    sclk_bad = 0; ready_busy = 0; have_rise = 0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] w, input bit keep_valid);
    bit ok = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_system);
      if (tx_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: word %0h not accepted within 300 cycles", w);
    end
    @(posedge clk_system); #1;
    if (!keep_valid) tx_valid = 1'b0;
  endtask

  task automatic wait_idle;
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_system);
      if (!busy && tx_ready && spi_ssn) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy=%0b tx_ready=%0b expected idle within 300 cycles", busy, tx_ready);
    end
    @(posedge clk_system); #1;
  endtask

  function automatic logic [W-1:0] mosi_word(input int first);
    logic [W-1:0] v = '0;
    for (int i = 0; i < int'(W); i++)
      v = {v[W-2:0], (first + i < mosi_q.size()) ? mosi_q[first + i] : 1'b0};
    return v;
  endfunction

  task automatic test_reset;
    rstn_system = 1'b0; tx_valid = 1'b0; tx_data = '0; hold_cs = 1'b0;
    tx_valid1 = 1'b0; tx_data1 = '0;
    repeat (3) @(negedge clk_system);
    tests++;
    if ({spi_ssn, spi_sclk, spi_mosi, tx_ready, rx_valid, busy} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_outputs: ssn,sclk,mosi,ready,rxv,busy=%b expected 100000",
               {spi_ssn, spi_sclk, spi_mosi, tx_ready, rx_valid, busy});
    end
    tests++;
    if (rx_data !== '0 || ssn1 !== 1'b1 || sclk1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_rx_data: rx_data=%0h ssn1=%0b sclk1=%0b expected 0,1,0", rx_data, ssn1, sclk1);
    end
    @(posedge clk_system); #1 rstn_system = 1'b1;
    @(negedge clk_system);
    tests++;
    if (tx_ready !== 1'b0) begin
      fails++; $display("FAIL ready_before_edge: tx_ready=%0b expected 0", tx_ready);
    end
    @(negedge clk_system);
    tests++;
    if (tx_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: tx_ready=%0b expected 1", tx_ready);
    end
    @(posedge clk_system); #1;
  endtask

  task automatic test_loopback_a5;
    clear_log(); miso_mode = 2; hold_cs = 1'b0;
    send(8'hA5, 0);
    wait_idle();
    tests++;
    if (mosi_q.size() != W || mosi_word(0) !== 8'hA5) begin
      fails++; $display("FAIL a5_mosi_bits: %0d bits value %0h expected 8 bits a5", mosi_q.size(), mosi_word(0));
    end
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      fails++; $display("FAIL a5_rx: %0d pulses first %0h expected 1 pulse a5", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h0);
    end
    tests++;
    if (low_len_q.size() != 1 || low_len_q[0] != SSN_LEN || win_rise_q[0] != W) begin
      fails++; $display("FAIL a5_ssn_window: windows=%0d len=%0d rises=%0d expected 1,%0d,%0d",
                        low_len_q.size(), low_len_q.size() ? low_len_q[0] : -1,
                        win_rise_q.size() ? win_rise_q[0] : -1, SSN_LEN, W);
    end
    tests++;
    if (rxv_cyc_q.size() != 1 || acc_cyc_q.size() != 1 || rxv_cyc_q[0] - acc_cyc_q[0] != RX_LAT) begin
      fails++; $display("FAIL a5_rx_latency: got %0d expected %0d",
                        (rxv_cyc_q.size() && acc_cyc_q.size()) ? rxv_cyc_q[0] - acc_cyc_q[0] : -1, RX_LAT);
    end
  endtask

  task automatic test_const_miso;
    clear_log(); hold_cs = 1'b0;
    miso_mode = 1; send(8'h00, 0); wait_idle();
    miso_mode = 0; send(8'hFF, 0); wait_idle();
    tests++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'hFF || rx_q[1] !== 8'h00) begin
      fails++; $display("FAIL const_miso_rx: %0d pulses %0h %0h expected ff 00", rx_q.size(),
                        rx_q.size() > 0 ? rx_q[0] : 8'h0, rx_q.size() > 1 ? rx_q[1] : 8'h0);
    end
    tests++;
    if (gap_q.size() != 1 || gap_q[0] < G || sclk_bad != 0) begin
      fails++; $display("FAIL const_miso_gap: gap=%0d sclk_high_while_ssn_high=%0d expected gap>=%0d and 0",
                        gap_q.size() ? gap_q[0] : -1, sclk_bad, G);
    end
  endtask

  task automatic test_hold_cs;
    clear_log(); miso_mode = 2; hold_cs = 1'b1;
    send(8'h12, 1);
    send(8'h34, 0);
    wait_idle();
    hold_cs = 1'b0;
    tests++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34) begin
      fails++; $display("FAIL hold_rx: %0d pulses %0h %0h expected 12 34", rx_q.size(),
                        rx_q.size() > 0 ? rx_q[0] : 8'h0, rx_q.size() > 1 ? rx_q[1] : 8'h0);
    end
    tests++;
    if (low_len_q.size() != 1 || win_rise_q[0] != 2 * W || low_len_q[0] != RX_LAT + SSN_LEN) begin
      fails++; $display("FAIL hold_window: windows=%0d rises=%0d len=%0d expected 1,%0d,%0d", low_len_q.size(),
                        win_rise_q.size() ? win_rise_q[0] : -1, low_len_q.size() ? low_len_q[0] : -1,
                        2 * W, RX_LAT + SSN_LEN);
    end
    tests++;
    if (rxv_cyc_q.size() != 2 || acc_cyc_q.size() != 2 || rxv_cyc_q[1] - acc_cyc_q[1] != RX_LAT) begin
      fails++; $display("FAIL hold_second_latency: got %0d expected %0d",
                        (rxv_cyc_q.size() > 1 && acc_cyc_q.size() > 1) ? rxv_cyc_q[1] - acc_cyc_q[1] : -1, RX_LAT);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] words [3];
    clear_log(); miso_mode = 2; hold_cs = 1'b0;
    for (int i = 0; i < 3; i++) words[i] = W'($urandom);
    send(words[0], 1);
    send(words[1], 1);
    send(words[2], 0);
    wait_idle();
    tests++;
    if (rx_q.size() != 3) begin
      fails++; $display("FAIL b2b_pulses: got %0d expected 3", rx_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== words[i]) begin
        fails++; $display("FAIL b2b_rx%0d: got %0h expected %0h", i, i < rx_q.size() ? rx_q[i] : 8'h0, words[i]);
      end
    end
    // ssn stays high through GAP plus the one IDLE cycle that offers tx_ready
    tests++;
    if (low_len_q.size() != 3 || gap_q.size() != 2 || gap_q[0] < G || gap_q[0] > G + 1 ||
        gap_q[1] < G || gap_q[1] > G + 1) begin
      fails++; $display("FAIL b2b_gaps: windows=%0d gaps=%0d first=%0d expected 3,2,%0d..%0d",
                        low_len_q.size(), gap_q.size(), gap_q.size() ? gap_q[0] : -1, G, G + 1);
    end
    tests++;
    if (ready_busy != 0) begin
      fails++; $display("FAIL b2b_ready_only_idle: ready-while-busy cycles=%0d expected 0", ready_busy);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] w, exp_rx;
    for (int n = 0; n < 8; n++) begin
      clear_log();
      w = W'($urandom);
      pat = W'($urandom);
      miso_mode = int'($urandom_range(0, 3));
      hold_cs = 1'($urandom_range(0, 1));
      exp_rx = (miso_mode == 0) ? '0 : (miso_mode == 1) ? '1 : (miso_mode == 2) ? w : pat;
      send(w, 0);
      wait_idle();
      tests++;
      if (rx_q.size() != 1 || rx_q[0] !== exp_rx || mosi_word(0) !== w) begin
        fails++; $display("FAIL rand%0d: mode=%0d rx=%0h mosi=%0h expected rx=%0h mosi=%0h", n, miso_mode,
                          rx_q.size() ? rx_q[0] : 8'h0, mosi_word(0), exp_rx, w);
      end
      tests++;
      if (low_len_q.size() != 1 || low_len_q[0] != SSN_LEN) begin
        fails++; $display("FAIL rand%0d_ssn_len: got %0d expected %0d", n,
                          low_len_q.size() ? low_len_q[0] : -1, SSN_LEN);
      end
    end
    hold_cs = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok = 0;
    clear_log(); miso_mode = 2; hold_cs = 1'b0;
    send(W'($urandom), 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_system);
      if (win_rises == 3) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin
      fails++; $display("FAIL reset_mid_wait: rises=%0d expected 3", win_rises);
    end
    #2 rstn_system = 1'b0;
    #1;
    tests++;
    if (spi_ssn !== 1'b1 || spi_sclk !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0) begin
      fails++; $display("FAIL reset_mid_async: ssn=%0b sclk=%0b busy=%0b rxv=%0b expected 1,0,0,0",
                        spi_ssn, spi_sclk, busy, rx_valid);
    end
    repeat (2) @(negedge clk_system);
    @(posedge clk_system); #1 rstn_system = 1'b1;
    wait_idle();
    tests++;
    if (rx_q.size() != 0) begin
      fails++; $display("FAIL reset_mid_no_rx: got %0d pulses expected 0", rx_q.size());
    end
    clear_log();
    send(8'h5A, 0);
    wait_idle();
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
      fails++; $display("FAIL reset_mid_next: %0d pulses %0h expected 1 pulse 5a", rx_q.size(),
                        rx_q.size() ? rx_q[0] : 8'h0);
    end
  endtask

  task automatic test_clk_div1;
    bit ok = 0;
    int first_busy = -1, last_busy = -1, rise1 = -1, rise2 = -1, rxv = -1, nrx = 0;
    logic prev = 1'b0;
    logic [W-1:0] rxd = '0;
    tx_data1 = 8'hC3; tx_valid1 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_system);
      if (tx_ready1) begin ok = 1; break; end
    end
    @(posedge clk_system); #1 tx_valid1 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_system);
      if (busy1) begin
        if (first_busy < 0) first_busy = c;
        last_busy = c;
      end
      if (sclk1 && !prev) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      prev = sclk1;
      if (rx_valid1) begin nrx++; rxv = c; rxd = rx_data1; end
    end
    tests++;
    if (!ok || rise1 != 1 + D1 || rise2 - rise1 != 2 * D1) begin
      fails++; $display("FAIL div1_sclk: accepted=%0b first_rise=%0d period=%0d expected 1,%0d,%0d",
                        ok, rise1, rise2 - rise1, 1 + D1, 2 * D1);
    end
    tests++;
    if (nrx != 1 || rxd !== 8'hC3 || rxv != D1 * (2 * W + 1) + 2) begin
      fails++; $display("FAIL div1_rx: pulses=%0d data=%0h cycle=%0d expected 1,c3,%0d",
                        nrx, rxd, rxv, D1 * (2 * W + 1) + 2);
    end
    tests++;
    if (first_busy != 1 || last_busy != D1 * (2 * W + 2) + 1 + G) begin
      fails++; $display("FAIL div1_busy: from %0d to %0d expected 1 to %0d",
                        first_busy, last_busy, D1 * (2 * W + 2) + 1 + G);
    end
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_const_miso();
    test_hold_cs();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_clk_div1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

endmodule
